// File: rtl/counter_pkg.sv
// Shared types and constants for the loadable down counter/timer.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int TERMINAL_VALUE = 1;

endpackage

// File: rtl/counter_down_load.sv
// Loadable down counter/timer with one-shot or auto-reload operation and a
// registered one-cycle terminal-count pulse.
module counter_down_load
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL_VALUE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Priority: load, then terminal event, then decrement, else hold.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = din;
            reload_d = din;
            state_d  = (din != '0) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q == TERM) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - TERM;
            end
        end
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    assign Q  = count_q;
    assign Qn = ~count_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_counter_down_load.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a cycle-level behavioural model of the timer.
module tb_counter_down_load;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] din = '0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic         tc;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q = 0;
    int m_rel = 0;
    bit m_run = 0;
    bit m_tc = 0;

    int tc_count;

    counter_down_load #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .din(din),
        .auto_reload(auto_reload),
        .Q(Q),
        .Qn(Qn),
        .tc(tc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input bit e,
                              input int d, input bit ar);
        if (r) begin
            m_q = 0; m_rel = 0; m_run = 0; m_tc = 0;
        end else if (l) begin
            m_q = d; m_rel = d; m_run = (d != 0); m_tc = 0;
        end else if (m_run && e && m_q == 1) begin
            m_tc = 1;
            if (ar) m_q = m_rel;
            else begin
                m_q = 0; m_run = 0;
            end
        end else begin
            if (m_run && e) m_q = m_q - 1;
            m_tc = 0;
        end
    endtask

    // Apply inputs, take one clock edge, then compare all outputs.
    task automatic step(input bit r, input bit l, input bit e,
                        input int d, input bit ar);
        rst = r; load = l; en = e; din = W'(d); auto_reload = ar;
        @(posedge clk);
        model_edge(r, l, e, d, ar);
        #1;
        chk("Q", int'(Q), m_q);
        chk("Qn", int'(Qn), (~m_q) & ((1 << W) - 1));
        chk("tc", int'(tc), int'(m_tc));
        chk("busy", int'(busy), int'(m_run));
        if (tc === 1'b1) tc_count++;
        $display("step rst=%0b load=%0b en=%0b din=%0d ar=%0b -> Q=%0d tc=%0b busy=%0b",
                 r, l, e, d, ar, Q, tc, busy);
    endtask

    initial begin
        // Reset and idle: en ignored without a load
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);

        // One-shot count from 3
        step(0, 1, 0, 3, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);

        // Auto-reload period 4 over 12 enabled cycles
        step(0, 1, 1, 4, 1);
        tc_count = 0;
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 1);
        chk("period4_pulses", tc_count, 3);

        // Enable gating
        step(0, 1, 0, 5, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("gated_Q", int'(Q), 3);

        // Load while a terminal event is pending, then reset with load
        step(0, 1, 0, 2, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 9, 0);
        chk("load_over_tc", int'(tc), 0);
        step(1, 1, 1, 7, 0);

        // Load zero stays idle
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);

        // Maximum period of 15
        step(0, 1, 0, 15, 1);
        tc_count = 0;
        for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 1);
        chk("period15_pulses", tc_count, 2);

        // Reload of 1: tc continuously high
        step(0, 1, 0, 1, 1);
        tc_count = 0;
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1);
        chk("period1_pulses", tc_count, 6);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
